// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory read streamer: FSM encoding and output buffer sizing.
package mem_stream_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry synchronous FIFO carrying a data word plus its last flag.
// Writes and reads may happen in the same cycle. The instantiating logic must never push while full.
module stream_skid_fifo
    import mem_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 push_last,
    input  logic                 pop,
    output logic [DATA_W-1:0]    head_data,
    output logic                 head_last,
    output logic [BUF_CNT_W-1:0] count
);

    logic [BUF_DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [BUF_DEPTH-1:0]             last_q, last_d;
    logic                             wr_ptr_q, wr_ptr_d;
    logic                             rd_ptr_q, rd_ptr_d;
    logic [BUF_CNT_W-1:0]             count_q, count_d;

    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            data_d[wr_ptr_q] = push_data;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + BUF_CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - BUF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mem_read_streamer.sv
// Burst read engine: walks a memory read port and returns the words as a valid/ready stream.
// MEM_STREAM_WRAP_EN: defined -> addresses wrap modulo depth; undefined -> burst truncated at top address.
module mem_read_streamer
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                cap_q, cap_d;
    logic                cap_last_q, cap_last_d;
    logic                zdone_q, zdone_d;

    logic [ADDR_W:0]     burst_len;
    logic [BUF_CNT_W-1:0] fifo_count;
    logic [BUF_CNT_W:0]  occ, limit;
    logic                pop, credit_ok, rd_issue;

`ifdef MEM_STREAM_WRAP_EN
    assign burst_len = cmd_len;
`else
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    logic [ADDR_W:0] room;
    assign room      = DEPTH - {1'b0, cmd_addr};
    assign burst_len = (cmd_len > room) ? room : cmd_len;
`endif

    assign pop       = out_valid & out_ready;
    assign cmd_ready = (state_q == S_IDLE);

    // A slot being popped this cycle is free again by the time the new read returns,
    // which is what lets the stream run at one beat per cycle with only two entries.
    assign occ       = {1'b0, fifo_count} + {{BUF_CNT_W{1'b0}}, cap_q};
    assign limit     = (BUF_CNT_W+1)'(BUF_DEPTH) + {{BUF_CNT_W{1'b0}}, pop};
    assign credit_ok = occ < limit;
    assign rd_issue  = (state_q == S_READ) && (rem_q != '0) && credit_ok;

    assign mem_rd_en   = rd_issue;
    assign mem_rd_addr = addr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        zdone_d    = 1'b0;
        cap_d      = rd_issue;
        cap_last_d = rd_issue && (rem_q == (ADDR_W+1)'(1));
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = burst_len;
                    if (burst_len == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (rd_issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && out_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            cap_q      <= 1'b0;
            cap_last_q <= 1'b0;
            zdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            cap_q      <= cap_d;
            cap_last_q <= cap_last_d;
            zdone_q    <= zdone_d;
        end
    end

    stream_skid_fifo #(.DATA_W(DATA_W)) u_buf (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (cap_q),
        .push_data (mem_dout),
        .push_last (cap_last_q),
        .pop       (pop),
        .head_data (out_data),
        .head_last (out_last),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign done      = zdone_q | (pop & out_last);

endmodule

// File: tb/tb_mem_read_streamer.sv
// Scoreboard bench for mem_read_streamer: directed bursts plus randomized commands and backpressure.
module tb_mem_read_streamer;

    logic       rd_clk;
    logic       rd_rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_addr;
    logic [4:0] cmd_len;
    logic       mem_rd_en;
    logic [3:0] mem_rd_addr;
    logic [7:0] mem_dout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       done;

    mem_read_streamer #(.ADDR_W(4), .DATA_W(8)) dut (
        .rd_clk      (rd_clk),
        .rd_rst_n    (rd_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_dout    (mem_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .done        (done)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    // Memory preloaded with mem[i] = A0 + i, one-cycle read latency.
    initial mem_dout = 8'h00;
    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_dout <= 8'(8'hA0 + {4'h0, mem_rd_addr});
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb_q[$];
    int    rd_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    beats = 0;
    int    done_cnt = 0;
    int    cyc = 0;
    int    fire_cyc = 0;
    int    first_beat_cyc = 0;
    int    last_beat_cyc = 0;
    int    ready_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_len(input int base, input int len);
        int n;
        n = len;
`ifndef MEM_STREAM_WRAP_EN
        if (n > 16 - base) n = 16 - base;
`endif
        return n;
    endfunction

    // Monitor / scoreboard
    initial begin
        bit    fire, pop, zdue, hold, first_pending, exp_done;
        logic [7:0] hold_d;
        logic  hold_l;
        int    outstanding, outs_after, n, a;
        beat_t e;
        zdue = 0; hold = 0; first_pending = 0; outstanding = 0;
        hold_d = '0; hold_l = 1'b0;
        forever begin
            @(negedge rd_clk);
            cyc++;
            if (!rd_rst_n) begin
                sb_q.delete();
                rd_q.delete();
                outstanding = 0;
                zdue = 0;
                hold = 0;
                continue;
            end
            fire = cmd_valid && cmd_ready;
            pop  = out_valid && out_ready;

            chk("cmd_ready_idle", cmd_ready, sb_q.size() == 0);
            if (sb_q.size() == 0) chk("idle_out_valid", out_valid, 0);

            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_d);
                chk("hold_last", out_last, hold_l);
            end
            hold   = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;

            outs_after = outstanding + (mem_rd_en ? 1 : 0) - (pop ? 1 : 0);
            if (mem_rd_en) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rd_unexpected: got read of addr %0d, none expected", mem_rd_addr);
                end else begin
                    chk("rd_addr", mem_rd_addr, rd_q.pop_front());
                end
                n_cmp++;
                if (outs_after > 2) begin
                    n_fail++;
                    $display("FAIL rd_outstanding: got %0d expected <=2", outs_after);
                end
            end
            outstanding = outs_after;

            exp_done = zdue || (pop && sb_q.size() > 0 && sb_q[0].last);
            if (done || exp_done) chk("done", done, exp_done);
            if (done) done_cnt++;
            zdue = 0;

            if (pop) begin
                beats++;
                last_beat_cyc = cyc;
                if (first_pending) begin
                    first_beat_cyc = cyc;
                    first_pending = 0;
                end
                if (sb_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL beat_unexpected: got %0h, none expected", out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", out_last, e.last);
                end
            end

            if (fire) begin
                fire_cyc = cyc;
                first_pending = 1;
                n = model_len(int'(cmd_addr), int'(cmd_len));
                if (n == 0) zdue = 1;
                for (int k = 0; k < n; k++) begin
                    a = (int'(cmd_addr) + k) % 16;
                    rd_q.push_back(a);
                    sb_q.push_back('{data: 8'(8'hA0 + a), last: (k == n - 1)});
                end
            end
        end
    end

    // out_ready shaping: 0 = held by driver, 1 = alternate, 2 = random
    initial begin
        forever begin
            @(posedge rd_clk);
            #1;
            case (ready_mode)
                1: out_ready = ~out_ready;
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end
    end

    // Caller is positioned just after a rising edge.
    task automatic send_cmd(input int a, input int l);
        bit ok;
        ok = 0;
        cmd_addr  = 4'(a);
        cmd_len   = 5'(l);
        cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge rd_clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge rd_clk);
        #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL cmd_accept_timeout: base %0d len %0d never accepted", a, l);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge rd_clk);
            if (sb_q.size() == 0 && rd_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge rd_clk);
        @(posedge rd_clk);
        #1;
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d beats still pending", sb_q.size());
        end
    endtask

    initial begin
        int b0, d0, exp_total, ba, ln;
        bit ok;
        rd_rst_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
        @(negedge rd_clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        @(posedge rd_clk);
        #1;

        // Base 2, len 3 at full throughput: first beat two edges after the fire edge
        // (three negedge samples after the sample that saw the handshake), then back to back.
        b0 = beats;
        send_cmd(2, 3);
        wait_idle();
        chk("b1_beats", beats - b0, 3);
        chk("b1_latency", first_beat_cyc - fire_cyc, 3);
        chk("b1_back_to_back", last_beat_cyc - first_beat_cyc, 2);

        // Base 0, len 4 with alternating backpressure
        ready_mode = 1;
        b0 = beats;
        send_cmd(0, 4);
        wait_idle();
        chk("b2_beats", beats - b0, 4);
        ready_mode = 0;
        out_ready  = 1'b1;

        // Zero-length command
        b0 = beats;
        d0 = done_cnt;
        send_cmd(7, 0);
        wait_idle();
        chk("len0_beats", beats - b0, 0);
        chk("len0_done_pulses", done_cnt - d0, 1);
        chk("len0_cmd_ready", cmd_ready, 1);

        // Top-of-memory burst
        b0 = beats;
        send_cmd(14, 4);
        wait_idle();
`ifdef MEM_STREAM_WRAP_EN
        chk("edge_beats", beats - b0, 4);
`else
        chk("edge_beats", beats - b0, 2);
`endif

        // Reset after the second beat of a len-8 burst
        b0 = beats;
        send_cmd(0, 8);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (beats >= b0 + 2) begin
                ok = 1;
                break;
            end
            @(posedge rd_clk);
            #1;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL rst_wait_timeout: got %0d beats expected 2", beats - b0);
        end
        out_ready = 1'b0;
        rd_rst_n  = 1'b0;
        @(posedge rd_clk);
        #1;
        rd_rst_n  = 1'b1;
        out_ready = 1'b1;
        @(negedge rd_clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        repeat (10) @(negedge rd_clk);
        chk("midrst_no_more_beats", beats - b0, 2);
        @(posedge rd_clk);
        #1;
        send_cmd(5, 1);
        wait_idle();
        chk("midrst_new_burst_beats", beats - b0, 3);

        // Second command raised while the first burst is still running
        b0 = beats;
        send_cmd(0, 8);
        send_cmd(9, 3);
        wait_idle();
        chk("overlap_beats", beats - b0, 8 + model_len(9, 3));

        // Randomized commands under random backpressure
        ready_mode = 2;
        b0 = beats;
        exp_total = 0;
        for (int i = 0; i < 30; i++) begin
            ba = $urandom_range(0, 15);
            ln = $urandom_range(0, 16);
            exp_total += model_len(ba, ln);
            send_cmd(ba, ln);
        end
        wait_idle();
        chk("rand_beats", beats - b0, exp_total);
        ready_mode = 0;
        out_ready  = 1'b1;

        repeat (2) @(posedge rd_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
